// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART transmit scheduler.
package uart_pkg;

  localparam int BYTE_W           = 8;
  localparam int DEF_CLKS_PER_BIT = 434;
  localparam int DEF_FRAME_TICKS  = 11;
  localparam int DEF_GAP_TICKS    = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_FRAME = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running baud divider: tick is high for one cycle every CLKS_PER_BIT cycles.
// Combinational tick from the count register; no backpressure, never stalls.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter and frame sequencer sharing one UART serializer; grant 1 cycle after valid, send 2 cycles after.
// Requesters wait with req_valid high until their one-cycle req_ready pulse; no internal queue.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FRAME_TICKS  = DEF_FRAME_TICKS,
  parameter int GAP_TICKS    = DEF_GAP_TICKS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [BYTE_W*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      tx_ena,
  output logic                      tx_send,
  output logic [BYTE_W-1:0]         tx_data,
  output logic                      busy,
  output logic [$clog2(N_REQ)-1:0]  grant_id
);

  localparam int IW   = $clog2(N_REQ);
  localparam int TMAX = (FRAME_TICKS > GAP_TICKS) ? FRAME_TICKS : GAP_TICKS;
  localparam int TW   = $clog2(TMAX + 1);

  state_t         state;
  logic [IW-1:0]  last_grant;
  logic [IW-1:0]  pick;
  logic           pick_vld;
  logic [TW-1:0]  tcnt;
  logic           tick;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign tx_ena = tick;

  // Descending scan so the smallest offset from last+1 is the final assignment.
  function automatic logic [IW:0] rr_pick(input logic [N_REQ-1:0] v, input logic [IW-1:0] last);
    logic [IW:0]   res;
    logic [IW-1:0] idx;
    res = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % N_REQ);
      if (v[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign {pick_vld, pick} = rr_pick(req_valid, last_grant);

  always_comb begin
    req_ready = '0;
    if (rst_n && state == ST_GRANT && pick_vld) req_ready[pick] = 1'b1;
  end

  assign busy = rst_n && (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      tx_send    <= 1'b0;
      tx_data    <= '0;
      grant_id   <= '0;
      last_grant <= IW'(N_REQ - 1);
      tcnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req_valid) state <= ST_GRANT;
        end
        ST_GRANT: begin
          if (pick_vld) begin
            tx_data    <= req_data[BYTE_W*int'(pick) +: BYTE_W];
            grant_id   <= pick;
            last_grant <= pick;
            tx_send    <= 1'b1;
            tcnt       <= '0;
            state      <= ST_FRAME;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_FRAME: begin
          if (tick) begin
            if (tcnt == TW'(FRAME_TICKS - 1)) begin
              tcnt    <= '0;
              tx_send <= 1'b0;
              state   <= ST_GAP;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        ST_GAP: begin
          if (tick) begin
            if (tcnt == TW'(GAP_TICKS - 1)) begin
              tcnt  <= '0;
              state <= (|req_valid) ? ST_GRANT : ST_IDLE;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
